// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data-memory responder with wait states and buffered response.
// Optional macro DMEM_WSTRB_EN enables per-byte write masking via req_wstrb.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        global_reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
`ifdef DMEM_WSTRB_EN
  localparam bit wstrb_en = 1'b1;
`else
  localparam bit wstrb_en = 1'b0;
`endif
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;
  state_t        state;
  logic [3:0]    cnt;
  logic          a_write;
  logic [31:0]   a_addr;
  logic [31:0]   a_wdata;
  logic [3:0]    a_lanes;
  logic [31:2]   off;
  logic          err;
  logic [AW-1:0] idx;
  logic [31:0]   mem [DEPTH_WORDS];
  // BASE_ADDR is aligned, so the word offset only needs the upper address bits
  assign off = a_addr[31:2] - BASE_ADDR[31:2];
  assign err = (a_addr[1:0] != 2'b00) || (a_addr < BASE_ADDR) || (off >= 30'(DEPTH_WORDS));
  assign idx = off[AW+1:2];
  always_ff @(posedge clk)
    if (!global_reset && state == S_ACCESS && a_write && !err)
      for (int i = 0; i < 4; i++)
        if (a_lanes[i]) mem[idx][8*i +: 8] <= a_wdata[8*i +: 8];
  always_ff @(posedge clk) begin
    if (global_reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            a_write   <= req_write;
            a_addr    <= req_addr;
            a_wdata   <= req_wdata;
            a_lanes   <= req_wstrb | {4{~wstrb_en}};
            req_ready <= 1'b0;
            state     <= WAIT_CYCLES == 0 ? S_ACCESS : S_WAIT;
            cnt       <= WAIT_CYCLES == 0 ? 4'd0 : 4'(WAIT_CYCLES - 1);
          end
        end
        S_WAIT: begin
          cnt   <= cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
          state <= cnt == 4'd0 ? S_ACCESS : S_WAIT;
        end
        S_ACCESS: begin
          rsp_valid <= 1'b1;
          rsp_err   <= err;
          rsp_rdata <= (a_write || err) ? '0 : mem[idx];
          state     <= S_RESP;
        end
        default: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
      endcase
    end
  end
endmodule
